// File: rtl/instr_encoder.sv
// RV32I instruction encoder and program loader.
// Decoded field sets come in over a valid/ready handshake. Each one is packed
// into a 32-bit machine word and written to consecutive instruction-memory
// addresses through a stallable write port. Illegal field combinations set a
// sticky error flag, and the word is still written.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [3:0]            op_class,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [31:0]           imm,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  done,
  output logic                  err
);

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IALU   = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_wr_done;
  logic                  w_wrap;
  logic                  w_start;
  logic [32:0]           w_enc;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Packs one field set; bit 32 flags an illegal or out-of-range combination.
  function automatic logic [32:0] encode(input logic [3:0]  cls,
                                         input logic [4:0]  f_rd,
                                         input logic [4:0]  f_rs1,
                                         input logic [4:0]  f_rs2,
                                         input logic [2:0]  f3,
                                         input logic        f7b5,
                                         input logic [31:0] f_imm);
    logic signed [31:0] s_imm;
    logic [31:0]        w;
    logic               e;
    logic               b30;
    logic [11:0]        i12;
    s_imm = f_imm;
    w     = NOP_WORD;
    e     = 1'b0;
    b30   = 1'b0;
    i12   = f_imm[11:0];
    case (cls)
      4'd0: begin
        b30 = ((f3 == 3'd0) || (f3 == 3'd5)) && f7b5;
        w   = {1'b0, b30, 5'b0, f_rs2, f_rs1, f3, f_rd, OP_R};
      end
      4'd1: begin
        if ((f3 == 3'd1) || (f3 == 3'd5)) begin
          // Shift-immediate: shamt in imm[4:0], upper bits carry only SRAI's bit 30.
          b30 = (f3 == 3'd5) && f7b5;
          i12 = {1'b0, b30, 5'b0, f_imm[4:0]};
          e   = |f_imm[31:5];
        end else begin
          e = !in_range(s_imm, -32'sd2048, 32'sd2047);
        end
        w = {i12, f_rs1, f3, f_rd, OP_IALU};
      end
      4'd2: begin
        e = !in_range(s_imm, -32'sd2048, 32'sd2047);
        w = {i12, f_rs1, f3, f_rd, OP_LOAD};
      end
      4'd3: begin
        e = !in_range(s_imm, -32'sd2048, 32'sd2047);
        w = {f_imm[11:5], f_rs2, f_rs1, f3, f_imm[4:0], OP_STORE};
      end
      4'd4: begin
        e = !in_range(s_imm, -32'sd4096, 32'sd4094) || f_imm[0];
        w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f3, f_imm[4:1], f_imm[11], OP_BRANCH};
      end
      4'd5: begin
        e = |f_imm[11:0];
        w = {f_imm[31:12], f_rd, OP_LUI};
      end
      4'd6: begin
        e = |f_imm[11:0];
        w = {f_imm[31:12], f_rd, OP_AUIPC};
      end
      4'd7: begin
        e = !in_range(s_imm, -32'sd1048576, 32'sd1048574) || f_imm[0];
        w = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, OP_JAL};
      end
      4'd8: begin
        e = !in_range(s_imm, -32'sd2048, 32'sd2047);
        w = {i12, f_rs1, f3, f_rd, OP_JALR};
      end
      default: begin
        e = 1'b1;
        w = NOP_WORD;
      end
    endcase
    return {e, w};
  endfunction

  assign in_ready  = (r_state == S_RUN) && (!r_valid || mem_ready);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign mem_valid = r_valid;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign w_accept  = in_valid && in_ready;
  assign w_wr_done = r_valid && mem_ready;
  assign w_wrap    = &r_addr[ADDR_WIDTH-1:2];
  assign w_start   = (r_state == S_IDLE) && start;
  assign w_enc     = encode(op_class, rd, rs1, rs2, funct3, funct7b5, imm);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: session start, last beat accepted, last write completed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN: if (w_wr_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output word register: loads on accept, holds while the memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_wdata <= w_enc[31:0];
    end else if (mem_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Write address: BASE_ADDR at start, +4 per completed write, wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_addr <= '0;
    else if (w_start)   r_addr <= ADDR_WIDTH'(BASE_ADDR);
    else if (w_wr_done) r_addr <= r_addr + ADDR_WIDTH'(4);
  end

  // Sticky error: cleared by an accepted start, set by bad fields or address wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_err <= 1'b0;
    else if (w_start)                                     r_err <= 1'b0;
    else if ((w_accept && w_enc[32]) || (w_wr_done && w_wrap)) r_err <= 1'b1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed field sets with hand-computed machine
// words, scoreboard queues popped by per-instance write monitors.
module tb_instr_encoder;

  localparam logic [3:0] C_R = 4'd0, C_I = 4'd1, C_LD = 4'd2, C_ST = 4'd3, C_BR = 4'd4;
  localparam logic [3:0] C_LUI = 4'd5, C_AUI = 4'd6, C_JAL = 4'd7, C_JALR = 4'd8, C_BAD = 4'd12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [3:0]  op_class = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [31:0] imm = '0;
  logic        mem_ready = 1'b1;

  logic        in_ready, mem_valid, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        in_ready_s, mem_valid_s, done_s, err_s;
  logic [3:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          prev_hs = 0;
  logic [7:0]  exp_addr = '0;
  logic [39:0] q_main[$];
  logic [39:0] q_small[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op_class(op_class), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7b5(funct7b5), .imm(imm), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err(err)
  );

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_last(in_last), .op_class(op_class), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7b5(funct7b5), .imm(imm), .mem_valid(mem_valid_s),
    .mem_ready(mem_ready), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .done(done_s), .err(err_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit-address instance.
  always @(negedge clk) begin : mon_main
    logic [39:0] e;
    if (rst_n && mem_valid && mem_ready) begin
      if (q_main.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL main unexpected write: got 0x%08h at 0x%02h, expected none", mem_wdata, mem_addr);
      end else begin
        e = q_main.pop_front();
        chk("main addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
        chk("main word", mem_wdata, e[31:0]);
      end
      prev_hs = last_hs;
      last_hs = cyc;
    end
  end

  // Monitor for the 4-bit-address instance.
  always @(negedge clk) begin : mon_small
    logic [39:0] e;
    if (rst_n && mem_valid_s && mem_ready) begin
      if (q_small.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL small unexpected write: got 0x%08h at 0x%01h, expected none", mem_wdata_s, mem_addr_s);
      end else begin
        e = q_small.pop_front();
        chk("small addr", {28'd0, mem_addr_s}, {28'd0, e[35:32]});
        chk("small word", mem_wdata_s, e[31:0]);
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                       input logic [31:0] im, input logic last);
    op_class = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7; imm = im;
    in_last = last;
    in_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [3:0] c, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                      input logic [31:0] im, input logic last, input logic [31:0] word);
    bit ok;
    ok = 1'b0;
    drive(c, d, s1, s2, f3, f7, im, last);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q_main.push_back({exp_addr, word});
        q_small.push_back({exp_addr, word});
        exp_addr = exp_addr + 8'd4;
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept timeout: word 0x%08h never accepted", word);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL done timeout: got 0 expected 1");
    end else begin
      chk("done after last write", cyc - last_hs, 1);
      chk("done small", {31'd0, done_s}, 1);
      @(negedge clk);
      chk("done width", {31'd0, done}, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 0);
    chk("rst mem_valid", {31'd0, mem_valid}, 0);
    chk("rst mem_addr", {24'd0, mem_addr}, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst err", {31'd0, err}, 0);
    @(posedge clk);
    #1;

    // addi x1, x0, 5
    do_start();
    send(C_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 32'h0050_0093);
    wait_done();
    chk("addi err", {31'd0, err}, 0);

    // sub x3,x1,x2 then beq x1,x2,-4, back-to-back
    do_start();
    send(C_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0, 32'h4020_81B3);
    send(C_BR, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
    wait_done();
    chk("b2b write spacing", last_hs - prev_hs, 1);
    chk("b2b err", {31'd0, err}, 0);

    // lui x5 legal, auipc with nonzero low bits flags err
    do_start();
    send(C_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
    chk("lui err", {31'd0, err}, 0);
    send(C_AUI, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0317);
    wait_done();
    chk("auipc err", {31'd0, err}, 1);

    // stall: mem_ready low for 3 cycles with a queued second beat
    do_start();
    mem_ready = 1'b0;
    send(C_I, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_8113);
    drive(C_ST, 5'd0, 5'd2, 5'd3, 3'd2, 1'b0, 32'd8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall in_ready", {31'd0, in_ready}, 0);
      chk("stall mem_valid", {31'd0, mem_valid}, 1);
      chk("stall mem_addr", {24'd0, mem_addr}, 0);
      chk("stall mem_wdata", mem_wdata, 32'hFFF0_8113);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    send(C_ST, 5'd0, 5'd2, 5'd3, 3'd2, 1'b0, 32'd8, 1'b1, 32'h0031_2423);
    wait_done();

    // imm out of range, start clears err, illegal class writes NOP
    do_start();
    send(C_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b1, 32'h8000_0093);
    wait_done();
    chk("imm2048 err", {31'd0, err}, 1);
    do_start();
    chk("start clears err", {31'd0, err}, 0);
    send(C_BAD, 5'd7, 5'd7, 5'd7, 3'd7, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0013);
    wait_done();
    chk("illegal class err", {31'd0, err}, 1);

    // five legal words: the 4-bit instance wraps to address 0 and flags err
    do_start();
    send(C_I, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd3, 1'b0, 32'h4030_D093);
    send(C_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b0, 32'h0080_00EF);
    send(C_JALR, 5'd0, 5'd1, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'h0000_8067);
    send(C_LD, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd4, 1'b0, 32'h0041_2283);
    send(C_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 32'h0020_81B3);
    wait_done();
    chk("wrap main err", {31'd0, err}, 0);
    chk("wrap small err", {31'd0, err_s}, 1);

    // reset in the middle of a stalled write
    do_start();
    send(C_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 1'b0, 32'h0010_0093);
    send(C_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0013);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("pre-reset mem_valid", {31'd0, mem_valid}, 1);
    chk("pre-reset mem_addr", {24'd0, mem_addr}, 4);
    chk("pre-reset err", {31'd0, err}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst mem_valid", {31'd0, mem_valid}, 0);
    chk("async rst mem_addr", {24'd0, mem_addr}, 0);
    chk("async rst mem_wdata", mem_wdata, 0);
    chk("async rst err", {31'd0, err}, 0);
    chk("async rst in_ready", {31'd0, in_ready}, 0);
    chk("async rst small valid", {31'd0, mem_valid_s}, 0);
    q_main.delete();
    q_small.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset mem_valid", {31'd0, mem_valid}, 0);
    chk("post-reset done", {31'd0, done}, 0);
    chk("scoreboard drained", q_main.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V RV32I instruction encoder and program loader. It accepts decoded instruction fields from a testbench or boot sequencer over a valid/ready handshake. Each field set is packed into a 32-bit machine word and written to consecutive instruction-memory addresses through a stallable write port. It is the inverse of the control-unit decode path: it produces the words that the fetch/decode stage later consumes, and it reports illegal field combinations.

## Interface
- ADDR_WIDTH, 8: byte-address width of the instruction memory write port.
- BASE_ADDR, 0: byte address of the first word written after `start`; must be a multiple of 4.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session at BASE_ADDR; clears `err`.
- in_valid  input  1  field set on the in_* inputs is valid.
- in_ready  output  1  encoder accepts the field set this cycle.
- in_last  input  1  marks the final instruction of the session.
- op_class  input  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9–15 illegal.
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  funct3 field.
- funct7b5  input  1  selects SUB/SRA (R) or SRAI (I-ALU).
- imm  input  32  signed immediate. For LUI/AUIPC it is the full upper value, with low 12 bits expected to be zero.
- mem_valid  output  1  write request valid.
- mem_ready  input  1  memory accepts the write.
- mem_addr  output  ADDR_WIDTH  byte address of the write.
- mem_wdata  output  32  encoded instruction word.
- done  output  1  one-cycle pulse after the last word is written.
- err  output  1  sticky error flag; cleared by `start` or reset.

## Operation
- Opcodes: R 0x33, I-ALU 0x13, LOAD 0x03, STORE 0x23, BRANCH 0x63, LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67. Field placement follows standard RV32I R/I/S/B/U/J formats.
- funct7 bit 30 is set to `funct7b5` only in these cases; everywhere else bit 30 comes from the format's immediate or is zero:
  - R with funct3 0 or 5;
  - I-ALU with funct3 5.
- I-ALU shifts (funct3 1 or 5) encode imm[4:0] as shamt with imm[11:5] forced to {0,funct7b5,00000}. imm outside 0..31 sets `err`.
- Range checks set `err`. The word is still encoded with truncated bits and still written.
  - I/S (including LOAD, JALR): imm must be in −2048..2047.
  - B: imm must be in −4096..4094 and even.
  - J: imm must be in ±1 MiB and even.
  - U: imm[11:0] must be zero.
- Illegal op_class: the word written is 0x00000013 (NOP) and `err` is set.
- FSM states:
  - IDLE: `in_ready`=0. Goes to RUN on `start`, loading the address counter with BASE_ADDR.
  - RUN: accepts field sets. Goes to DRAIN when a beat with `in_last`=1 is accepted.
  - DRAIN: `in_ready`=0. Goes to DONE when that last word's write completes.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- The address counter advances by 4 on each completed write (`mem_valid` & `mem_ready`). If it wraps past 2^ADDR_WIDTH−4, it returns to 0 and `err` is set.

## Timing
- Reset values: state IDLE; `in_ready` 0, `mem_valid` 0, `mem_addr` 0, `mem_wdata` 0, `done` 0, `err` 0.
- An input beat is accepted when `in_valid` & `in_ready`. Latency is 1: the encoded word appears on `mem_wdata` with `mem_valid`=1 on the next cycle, registered.
- `in_ready` = (state==RUN) & (!`mem_valid` | `mem_ready`). This allows one write per cycle with no bubbles at full throughput.
- While `mem_valid`=1 and `mem_ready`=0, `mem_valid`, `mem_addr` and `mem_wdata` hold stable.
- `err` updates in the same cycle the offending word is registered.
- `done` rises on the cycle after the final write handshake.
- Reset mid-session: everything returns to reset values immediately; a pending write is dropped.

## Test plan
- `start`, then one beat: I-ALU, rd=1, rs1=0, funct3=0, imm=5, in_last=1 → next cycle `mem_wdata`=0x00500093 at `mem_addr`=0; `done` pulses one cycle after the write; `err`=0.
- R, rd=3, rs1=1, rs2=2, funct3=0, funct7b5=1, then BRANCH rs1=1, rs2=2, funct3=0, imm=−4 back-to-back with `mem_ready`=1 → words 0x402081B3 at address 0 and 0xFE208EE3 at address 4, written on consecutive cycles.
- LUI rd=5, imm=0x12345000 → 0x123452B7. AUIPC with imm=0x00000010 → `err`=1.
- Hold `mem_ready`=0 for 3 cycles with a queued second beat → `in_ready`=0 and outputs stable for those cycles; both words are written in order once `mem_ready`=1.
- I-ALU rd=1, rs1=0, imm=2048 → word 0x80000093 written, `err`=1. A subsequent `start` clears `err`. op_class=12 → NOP 0x00000013 written and `err`=1.
- ADDR_WIDTH=4: write 5 words → the fifth is written at address 0 and `err`=1. Assert `rst_n`=0 mid-write → all outputs return to 0 asynchronously.
